// File: rtl/data_reg_pkg.sv
// Shared defaults and datapath word type for the data_reg storage register.
// Byte-lane writes are enabled in data_reg by defining DATA_REG_BYTE_WRITE_EN.
package data_reg_pkg;

  localparam int          DATA_REG_WIDTH_DEF   = 32;
  localparam logic [31:0] DATA_REG_RST_VAL_DEF = '0;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/data_reg_lane.sv
// One 8-bit slice of data_reg, used when DATA_REG_BYTE_WRITE_EN is defined.
// Synchronous active-high reset has priority over the lane write enable.
module data_reg_lane #(
  parameter logic [7:0] RST_BYTE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);

  // Ternary form lets an unknown enable propagate X in simulation.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_q <= RST_BYTE;
    else       o_q <= i_we ? i_d : o_q;
  end

endmodule

// File: rtl/data_reg.sv
// Clocked storage register with write enable and synchronous reset to RST_VAL.
// Define DATA_REG_BYTE_WRITE_EN to add per-byte enables (i_be); WIDTH must then be a multiple of 8.
module data_reg
  import data_reg_pkg::*;
#(
  parameter int               WIDTH   = DATA_REG_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DATA_REG_RST_VAL_DEF)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [WIDTH-1:0]   i_in,
`ifdef DATA_REG_BYTE_WRITE_EN
  input  logic [WIDTH/8-1:0] i_be,
`endif
  output logic [WIDTH-1:0]   o_out
);

`ifdef DATA_REG_BYTE_WRITE_EN
  localparam int NUM_LANES = WIDTH / 8;

  if (WIDTH % 8 != 0) begin : g_width_chk
    $error("data_reg: WIDTH must be a multiple of 8 with byte writes enabled");
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic w_lane_we;
    assign w_lane_we = i_wr & i_be[i];

    data_reg_lane #(
      .RST_BYTE (RST_VAL[8*i +: 8])
    ) u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_we  (w_lane_we),
      .i_d   (i_in[8*i +: 8]),
      .o_q   (o_out[8*i +: 8])
    );
  end
`else
  // Reset wins over a coincident write; the incoming data is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_out <= RST_VAL;
    else       o_out <= i_wr ? i_in : o_out;
  end
`endif

endmodule

// File: tb/tb_data_reg.sv
// Directed self-checking bench for data_reg (32-bit, reset value 0).
// The byte-enable steps run only when DATA_REG_BYTE_WRITE_EN is defined.
module tb_data_reg;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [31:0] din;
  logic [31:0] dout;
`ifdef DATA_REG_BYTE_WRITE_EN
  logic [3:0]  be;
`endif

  int n_total = 0;
  int n_pass  = 0;

  data_reg #(
    .WIDTH   (32),
    .RST_VAL (32'h0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_wr  (wr),
    .i_in  (din),
`ifdef DATA_REG_BYTE_WRITE_EN
    .i_be  (be),
`endif
    .o_out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    n_total++;
    assert (dout === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, dout, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    din = 32'h0;
`ifdef DATA_REG_BYTE_WRITE_EN
    be  = 4'hF;
`endif

    // 1: reset clears the register
    step();
    check("reset", 32'h0000_0000);

    // 2: single write then 16 idle edges with in=0
    rst = 1'b0;
    din = 32'hA5A5_A5A5;
    wr  = 1'b1;
    step();
    check("write_a5", 32'hA5A5_A5A5);
    din = 32'h0;
    wr  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("hold_a5_%0d", i), 32'hA5A5_A5A5);
    end

    // no combinational path: changing in mid-cycle must not reach out
    din = 32'h5A5A_5A5A;
    wr  = 1'b1;
    #2;
    check("no_comb_path", 32'hA5A5_A5A5);
    wr  = 1'b0;

    // 3: reset mid-operation, then immediate write and hold
    rst = 1'b1;
    step();
    check("mid_reset", 32'h0000_0000);
    rst = 1'b0;
    din = 32'hDEAD_BEEF;
    wr  = 1'b1;
    step();
    check("write_after_reset", 32'hDEAD_BEEF);
    wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 32'h1111_1111 * i;
      step();
      check($sformatf("hold_db_%0d", i), 32'hDEAD_BEEF);
    end

    // 4: reset has priority over a coincident write
    rst = 1'b1;
    wr  = 1'b1;
    din = 32'hFFFF_FFFF;
    step();
    check("rst_over_wr", 32'h0000_0000);

    // 5: back-to-back writes
    rst = 1'b0;
    din = 32'h1;
    step();
    check("b2b_1", 32'h0000_0001);
    din = 32'h2;
    step();
    check("b2b_2", 32'h0000_0002);
    din = 32'h3;
    step();
    check("b2b_3", 32'h0000_0003);
    wr = 1'b0;
    din = 32'h4;
    step();
    check("b2b_hold", 32'h0000_0003);

`ifdef DATA_REG_BYTE_WRITE_EN
    // 6: byte-lane writes
    din = 32'hDEAD_BEEF;
    wr  = 1'b1;
    be  = 4'hF;
    step();
    check("be_full", 32'hDEAD_BEEF);
    din = 32'h1122_3344;
    be  = 4'b0101;
    step();
    check("be_0101", 32'hDE22_BE44);
    din = 32'hFFFF_FFFF;
    be  = 4'b0000;
    step();
    check("be_none", 32'hDE22_BE44);
    rst = 1'b1;
    be  = 4'b0000;
    step();
    check("be_reset", 32'h0000_0000);
    rst = 1'b0;
    wr  = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
